// File: rtl/clct_sort_sequencer_pkg.sv
// Shared constants, FSM encoding and CLCT record type for the two-pass CLCT sorter.
package clct_sort_pkg;

    localparam int MXCFEB  = 7;
    localparam int MXPATB  = 7;
    localparam int MXKEYB  = 5;
    localparam int MXKEYBX = 8;
    localparam int MXBNDB  = 5;
    localparam int MXSORTB = MXPATB - 1;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_PASS1 = 3'd1;
    localparam logic [2:0] ST_BLANK = 3'd2;
    localparam logic [2:0] ST_PASS2 = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    typedef struct packed {
        logic               vld;
        logic [MXPATB-1:0]  pat;
        logic [MXKEYBX-1:0] key;
        logic [MXBNDB-1:0]  bend;
    } clct_t;

    // The lowest pattern bit is a left/right flag and does not rank quality.
    function automatic logic [MXSORTB-1:0] sort_key(input logic [MXPATB-1:0] pat);
        return pat[MXPATB-1:1];
    endfunction

endpackage

// File: rtl/clct_sort_sequencer_if.sv
// Candidate bus and result bus between pattern finders and the CLCT sequencer.
interface clct_sort_sequencer_if;
    import clct_sort_pkg::*;

    logic                       start;
    logic [MXCFEB*MXPATB-1:0]   pat;
    logic [MXCFEB*MXKEYB-1:0]   key;
    logic [MXCFEB*MXBNDB-1:0]   bend;
    logic [MXSORTB-1:0]         pat_thresh;
    logic [3:0]                 busy_hw;
    logic                       busy;
    logic                       done;
    logic                       clct0_vld;
    logic                       clct1_vld;
    logic [MXPATB-1:0]          clct0_pat;
    logic [MXPATB-1:0]          clct1_pat;
    logic [MXKEYBX-1:0]         clct0_key;
    logic [MXKEYBX-1:0]         clct1_key;
    logic [MXBNDB-1:0]          clct0_bend;
    logic [MXBNDB-1:0]          clct1_bend;

    modport master (
        output start, pat, key, bend, pat_thresh, busy_hw,
        input  busy, done, clct0_vld, clct1_vld, clct0_pat, clct1_pat,
               clct0_key, clct1_key, clct0_bend, clct1_bend
    );

    modport slave (
        input  start, pat, key, bend, pat_thresh, busy_hw,
        output busy, done, clct0_vld, clct1_vld, clct0_pat, clct1_pat,
               clct0_key, clct1_key, clct0_bend, clct1_bend
    );

endinterface

// File: rtl/clct_sort_sequencer_sort7.sv
// Combinational masked 7-way best-candidate picker; ties resolve to the lowest index.
module clct_sort7
    import clct_sort_pkg::*;
(
    input  logic [MXCFEB*MXSORTB-1:0] i_sort,
    input  logic [MXCFEB-1:0]         i_mask,
    output logic [2:0]                o_idx,
    output logic [MXSORTB-1:0]        o_sort,
    output logic                      o_all_masked
);

    // A candidate only displaces the running best on a strictly larger key.
    always_comb begin
        o_idx        = 3'd0;
        o_sort       = {MXSORTB{1'b0}};
        o_all_masked = 1'b1;
        for (int i = 0; i < MXCFEB; i++) begin
            if (!i_mask[i] && (o_all_masked || (i_sort[i*MXSORTB +: MXSORTB] > o_sort))) begin
                o_idx        = 3'(i);
                o_sort       = i_sort[i*MXSORTB +: MXSORTB];
                o_all_masked = 1'b0;
            end else begin
                o_idx        = o_idx;
            end
        end
    end

endmodule

// File: rtl/clct_sort_sequencer.sv
// Two-pass CLCT sequencer: pick clct0, blank a busy-key window around it, pick clct1.
module clct_sort_sequencer
    import clct_sort_pkg::*;
(
    input  logic                  i_clock,
    input  logic                  i_reset,
    clct_sort_sequencer_if.slave  bus
);

    logic [2:0]                 r_state;
    logic [MXCFEB*MXPATB-1:0]   r_pat;
    logic [MXCFEB*MXKEYB-1:0]   r_key;
    logic [MXCFEB*MXBNDB-1:0]   r_bend;
    logic [MXSORTB-1:0]         r_thresh;
    logic [3:0]                 r_busy_hw;
    logic [MXCFEB-1:0]          r_mask;
    clct_t                      r_clct0_shadow;
    clct_t                      r_out0;
    clct_t                      r_out1;
    logic                       r_busy;
    logic                       r_done;

    logic [MXCFEB*MXSORTB-1:0]  w_sort;
    logic [MXCFEB-1:0]          w_cmp_mask;
    logic [MXCFEB-1:0]          w_blank;
    logic [2:0]                 w_idx;
    logic [MXSORTB-1:0]         w_win_sort;
    logic                       w_all_masked;
    clct_t                      w_win;

    // Sort keys from captured patterns; the blank mask applies only during the second pass.
    always_comb begin
        w_sort = {(MXCFEB*MXSORTB){1'b0}};
        for (int i = 0; i < MXCFEB; i++) begin
            w_sort[i*MXSORTB +: MXSORTB] = sort_key(r_pat[i*MXPATB +: MXPATB]);
        end
        if (r_state == ST_PASS2) begin
            w_cmp_mask = r_mask;
        end else begin
            w_cmp_mask = {MXCFEB{1'b0}};
        end
    end

    clct_sort7 u_sort7 (
        .i_sort       (w_sort),
        .i_mask       (w_cmp_mask),
        .o_idx        (w_idx),
        .o_sort       (w_win_sort),
        .o_all_masked (w_all_masked)
    );

    // Expand the winning index into a CLCT record; all-masked yields an empty record.
    always_comb begin
        w_win.vld  = 1'b0;
        w_win.pat  = {MXPATB{1'b0}};
        w_win.key  = {MXKEYBX{1'b0}};
        w_win.bend = {MXBNDB{1'b0}};
        if (!w_all_masked) begin
            w_win.vld  = (w_win_sort != {MXSORTB{1'b0}}) && (w_win_sort >= r_thresh);
            w_win.pat  = r_pat[w_idx*MXPATB +: MXPATB];
            w_win.key  = {w_idx, r_key[w_idx*MXKEYB +: MXKEYB]};
            w_win.bend = r_bend[w_idx*MXBNDB +: MXBNDB];
        end else begin
            w_win.vld  = 1'b0;
        end
    end

    // Busy-key window in global half-strip space, so it spans CFEB boundaries without wrapping.
    always_comb begin : blank_calc
        logic [MXKEYBX-1:0]        v_gkey;
        logic signed [MXKEYBX:0]   v_diff;
        logic [MXKEYBX:0]          v_dist;
        w_blank = {MXCFEB{1'b0}};
        v_gkey  = {MXKEYBX{1'b0}};
        v_diff  = 9'sd0;
        v_dist  = 9'd0;
        for (int i = 0; i < MXCFEB; i++) begin
            v_gkey = {3'(i), r_key[i*MXKEYB +: MXKEYB]};
            v_diff = $signed({1'b0, v_gkey}) - $signed({1'b0, r_clct0_shadow.key});
            if (v_diff < 9'sd0) begin
                v_dist = $unsigned(-v_diff);
            end else begin
                v_dist = $unsigned(v_diff);
            end
            w_blank[i] = (3'(i) == r_clct0_shadow.key[MXKEYBX-1:MXKEYB]) ||
                         (v_dist <= {5'd0, r_busy_hw});
        end
        if (!r_clct0_shadow.vld) begin
            w_blank = {MXCFEB{1'b1}};
        end else begin
            w_blank = w_blank;
        end
    end

    // Sequencer FSM with input capture, shadow, mask and output registers.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state        <= ST_IDLE;
            r_pat          <= {(MXCFEB*MXPATB){1'b0}};
            r_key          <= {(MXCFEB*MXKEYB){1'b0}};
            r_bend         <= {(MXCFEB*MXBNDB){1'b0}};
            r_thresh       <= {MXSORTB{1'b0}};
            r_busy_hw      <= 4'd0;
            r_mask         <= {MXCFEB{1'b0}};
            r_clct0_shadow <= {$bits(clct_t){1'b0}};
            r_out0         <= {$bits(clct_t){1'b0}};
            r_out1         <= {$bits(clct_t){1'b0}};
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_pat     <= bus.pat;
                        r_key     <= bus.key;
                        r_bend    <= bus.bend;
                        r_thresh  <= bus.pat_thresh;
                        r_busy_hw <= bus.busy_hw;
                        r_busy    <= 1'b1;
                        r_state   <= ST_PASS1;
                    end else begin
                        r_state   <= ST_IDLE;
                    end
                end
                ST_PASS1: begin
                    r_clct0_shadow <= w_win;
                    r_state        <= ST_BLANK;
                end
                ST_BLANK: begin
                    r_mask  <= w_blank;
                    r_state <= ST_PASS2;
                end
                ST_PASS2: begin
                    r_out0  <= r_clct0_shadow;
                    r_out1  <= w_win;
                    r_done  <= 1'b1;
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.clct0_vld  = r_out0.vld;
    assign bus.clct0_pat  = r_out0.pat;
    assign bus.clct0_key  = r_out0.key;
    assign bus.clct0_bend = r_out0.bend;
    assign bus.clct1_vld  = r_out1.vld;
    assign bus.clct1_pat  = r_out1.pat;
    assign bus.clct1_key  = r_out1.key;
    assign bus.clct1_bend = r_out1.bend;

endmodule
